// File: rtl/ntt_pkg.sv
// Shared definitions for the NTT sequencer and the butterfly datapath:
// polynomial size, transform mode codes and the sequencer state encoding.
package ntt_pkg;

    localparam int N    = 256;
    localparam int LOGN = 8;

    localparam logic [1:0] MODE_NTT  = 2'b00;
    localparam logic [1:0] MODE_INTT = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } ntt_state_t;

    // log2 of the butterfly span for a layer: NTT halves the span each layer
    // starting from N/2, INTT doubles it starting from 2.
    function automatic logic [2:0] layerShift(input logic [1:0] m, input logic [2:0] l);
        layerShift = (m == MODE_INTT) ? (l + 3'd1) : (3'd7 - l);
    endfunction

endpackage

// File: rtl/ntt_delay_line.sv
// Fixed-depth shift register used to align the read strobe/addresses with
// the butterfly results coming back for write-back.
module ntt_delay_line #(
    parameter int DEPTH = 14,
    parameter int WIDTH = 17
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_pipe [DEPTH];

    // Shift one stage per cycle; a reset empties every stage so no stale
    // write strobe can escape after an aborted transform.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign o_q = r_pipe[DEPTH-1];

endmodule

// File: rtl/ntt_ctrl.sv
// In-place NTT/INTT address sequencer: walks 7 butterfly layers of 128
// butterflies each, drives read addresses, twiddle index and butterfly mode,
// and produces write-back strobes aligned to the butterfly output.
module ntt_ctrl
    import ntt_pkg::*;
#(
    parameter int BF_LAT = 13,
    parameter int RD_LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] mode,
    output logic       busy,
    output logic       done,
    output logic [1:0] bf_mode,
    output logic       rd_en,
    output logic [7:0] rd_addr_a,
    output logic [7:0] rd_addr_b,
    output logic [6:0] tw_idx,
    output logic       wr_en,
    output logic [7:0] wr_addr_a,
    output logic [7:0] wr_addr_b
);

    localparam int D    = RD_LAT + BF_LAT;
    localparam int DW   = $clog2(D + 1);
    localparam int AW   = LOGN;
    localparam int JW   = LOGN - 1;
    localparam int HALF = N / 2;
    localparam int PW   = 1 + 2 * AW;

    ntt_state_t    r_state;
    ntt_state_t    w_nextState;
    logic [2:0]    r_layer;
    logic [JW-1:0] r_j;
    logic [DW-1:0] r_drainCnt;
    logic [1:0]    r_bfMode;

    logic [2:0]    w_shift;
    logic [AW-1:0] w_j8;
    logic [AW-1:0] w_lowMask;
    logic [AW-1:0] w_len;
    logic [AW-1:0] w_addrA;
    logic [AW-1:0] w_addrB;
    logic [JW-1:0] w_group;
    logic [JW-1:0] w_tw;
    logic [PW-1:0] w_wrPipe;

    // State register; reset drops straight back to IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Layer, butterfly and drain counters plus the latched transform mode.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_layer    <= '0;
            r_j        <= '0;
            r_drainCnt <= '0;
            r_bfMode   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_nextState == ST_RUN) begin
                        r_bfMode <= mode;
                        r_layer  <= '0;
                        r_j      <= '0;
                    end
                end
                ST_RUN: begin
                    r_j        <= r_j + JW'(1);
                    r_drainCnt <= '0;
                end
                ST_DRAIN: begin
                    r_drainCnt <= r_drainCnt + DW'(1);
                    if (w_nextState != ST_DRAIN) begin
                        r_layer <= r_layer + 3'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state sequencing and the status/strobe outputs of each state.
    always_comb begin
        w_nextState = r_state;
        rd_en       = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start && !mode[1]) begin
                    w_nextState = ST_RUN;
                end
            end
            ST_RUN: begin
                rd_en = 1'b1;
                busy  = 1'b1;
                if (r_j == JW'(HALF - 1)) begin
                    w_nextState = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (r_drainCnt == DW'(D - 1)) begin
                    w_nextState = (r_layer == 3'(LOGN - 2)) ? ST_DONE : ST_RUN;
                end
            end
            ST_DONE: begin
                done        = 1'b1;
                w_nextState = ST_IDLE;
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // Butterfly addressing: insert a zero at bit s of j to get the upper leg,
    // the lower leg is span len away, and the twiddle follows the group index.
    always_comb begin
        w_shift   = layerShift(r_bfMode, r_layer);
        w_j8      = {1'b0, r_j};
        w_lowMask = (AW'(1) << w_shift) - AW'(1);
        w_len     = AW'(1) << w_shift;
        w_addrA   = (((w_j8 >> w_shift) << w_shift) << 1) | (w_j8 & w_lowMask);
        w_addrB   = w_addrA | w_len;
        w_group   = r_j >> w_shift;
        if (r_bfMode == MODE_INTT) begin
            w_tw = (JW'(HALF - 1) >> r_layer) - w_group;
        end else begin
            w_tw = (JW'(1) << r_layer) + w_group;
        end
    end

    assign bf_mode   = r_bfMode;
    assign rd_addr_a = rd_en ? w_addrA : '0;
    assign rd_addr_b = rd_en ? w_addrB : '0;
    assign tw_idx    = rd_en ? w_tw : '0;

    ntt_delay_line #(
        .DEPTH (D),
        .WIDTH (PW)
    ) u_wrDelay (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_d     ({rd_en, rd_addr_a, rd_addr_b}),
        .o_q     (w_wrPipe)
    );

    assign {wr_en, wr_addr_a, wr_addr_b} = w_wrPipe;

endmodule

// File: tb/tb_ntt_ctrl.sv
// Directed bench for ntt_ctrl: reset behaviour, NTT/INTT address vectors,
// read-to-write alignment, run length, ignored starts and mid-run reset.
module tb_ntt_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [1:0] mode = 2'b00;
    logic       busy;
    logic       done;
    logic [1:0] bf_mode;
    logic       rd_en;
    logic [7:0] rd_addr_a;
    logic [7:0] rd_addr_b;
    logic [6:0] tw_idx;
    logic       wr_en;
    logic [7:0] wr_addr_a;
    logic [7:0] wr_addr_b;

    int checks = 0;
    int errors = 0;

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    ntt_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .busy      (busy),
        .done      (done),
        .bf_mode   (bf_mode),
        .rd_en     (rd_en),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .tw_idx    (tw_idx),
        .wr_en     (wr_en),
        .wr_addr_a (wr_addr_a),
        .wr_addr_b (wr_addr_b)
    );

    // One-cycle start pulse; returns on the negedge of the first busy cycle.
    task automatic applyStimulus(input logic [1:0] m);
        @(negedge clk);
        start = 1'b1;
        mode  = m;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        int bad = 0;
        logic [44:0] lastVal = '0;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            start = i[0];
            mode  = 2'b00;
            @(negedge clk);
            lastVal = {busy, done, rd_en, wr_en, bf_mode, rd_addr_a, rd_addr_b, tw_idx, wr_addr_a, wr_addr_b};
            if (lastVal !== '0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: %0d nonzero samples (last %h), required 0", bad, lastVal);
        end
        start = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || rd_en !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_release_idle: busy=%b rd_en=%b, required 0/0", busy, rd_en);
        end
    endtask

    task automatic test_ntt_sweep();
        int expL[5] = '{0, 0, 1, 6, 6};
        int expJ[5] = '{0, 127, 64, 0, 127};
        int expA[5] = '{0, 127, 128, 0, 253};
        int expB[5] = '{128, 255, 192, 2, 255};
        int expT[5] = '{1, 1, 3, 64, 127};
        int rdCount = 0;
        int hits = 0;
        int l;
        int j;
        logic doneSeen = 1'b0;
        applyStimulus(2'b00);
        for (int c = 0; c < 1100 && !doneSeen; c++) begin
            if (done === 1'b1) doneSeen = 1'b1;
            if (rd_en === 1'b1) begin
                l = rdCount / 128;
                j = rdCount % 128;
                for (int k = 0; k < 5; k++) begin
                    if (l == expL[k] && j == expJ[k]) begin
                        hits++;
                        checks++;
                        if (rd_addr_a !== 8'(expA[k]) || rd_addr_b !== 8'(expB[k]) || tw_idx !== 7'(expT[k])) begin
                            errors++;
                            $display("[TB] FAIL ntt_l%0d_j%0d: a=%0d b=%0d tw=%0d, required a=%0d b=%0d tw=%0d",
                                     l, j, rd_addr_a, rd_addr_b, tw_idx, expA[k], expB[k], expT[k]);
                        end
                    end
                end
                rdCount++;
            end
            if (!doneSeen) @(negedge clk);
        end
        checks++;
        if (hits != 5) begin
            errors++;
            $display("[TB] FAIL ntt_vectors_hit: %0d, required 5", hits);
        end
        checks++;
        if (rdCount != 896) begin
            errors++;
            $display("[TB] FAIL ntt_issue_count: %0d, required 896", rdCount);
        end
        checks++;
        if (!doneSeen) begin
            errors++;
            $display("[TB] FAIL ntt_done_seen: no done within 1100 cycles, required done");
        end
        checks++;
        if (bf_mode !== 2'b00) begin
            errors++;
            $display("[TB] FAIL ntt_bf_mode: %b, required 00", bf_mode);
        end
    endtask

    task automatic test_intt_sweep();
        int expL[3] = '{0, 0, 6};
        int expJ[3] = '{0, 2, 0};
        int expA[3] = '{0, 4, 0};
        int expB[3] = '{2, 6, 128};
        int expT[3] = '{127, 126, 1};
        int rdCount = 0;
        int hits = 0;
        int l;
        int j;
        logic doneSeen = 1'b0;
        applyStimulus(2'b01);
        checks++;
        if (bf_mode !== 2'b01) begin
            errors++;
            $display("[TB] FAIL intt_bf_mode: %b, required 01", bf_mode);
        end
        for (int c = 0; c < 1100 && !doneSeen; c++) begin
            if (done === 1'b1) doneSeen = 1'b1;
            if (rd_en === 1'b1) begin
                l = rdCount / 128;
                j = rdCount % 128;
                for (int k = 0; k < 3; k++) begin
                    if (l == expL[k] && j == expJ[k]) begin
                        hits++;
                        checks++;
                        if (rd_addr_a !== 8'(expA[k]) || rd_addr_b !== 8'(expB[k]) || tw_idx !== 7'(expT[k])) begin
                            errors++;
                            $display("[TB] FAIL intt_l%0d_j%0d: a=%0d b=%0d tw=%0d, required a=%0d b=%0d tw=%0d",
                                     l, j, rd_addr_a, rd_addr_b, tw_idx, expA[k], expB[k], expT[k]);
                        end
                    end
                end
                rdCount++;
            end
            if (!doneSeen) @(negedge clk);
        end
        checks++;
        if (hits != 3 || rdCount != 896 || !doneSeen) begin
            errors++;
            $display("[TB] FAIL intt_run: hits=%0d issues=%0d done=%b, required 3/896/1", hits, rdCount, doneSeen);
        end
    endtask

    task automatic test_alignment();
        logic [16:0] hist [1100];
        int firstRd = -1;
        int firstWr = -1;
        int busyCnt = 0;
        int doneCnt = 0;
        int doneAt = -1;
        int wrCnt = 0;
        int alignBad = 0;
        logic [7:0] firstWrA = '0;
        logic [7:0] firstWrB = '0;
        logic doneBusy = 1'b1;
        applyStimulus(2'b00);
        for (int c = 0; c < 1020; c++) begin
            hist[c] = {rd_en, rd_addr_a, rd_addr_b};
            if (rd_en === 1'b1 && firstRd < 0) firstRd = c;
            if (wr_en === 1'b1) begin
                wrCnt++;
                if (firstWr < 0) begin
                    firstWr  = c;
                    firstWrA = wr_addr_a;
                    firstWrB = wr_addr_b;
                end
            end
            if (c >= 14 && {wr_en, wr_addr_a, wr_addr_b} !== hist[c-14]) alignBad++;
            if (busy === 1'b1) busyCnt++;
            if (done === 1'b1) begin
                doneCnt++;
                doneAt   = c;
                doneBusy = busy;
            end
            @(negedge clk);
        end
        checks++;
        if (firstRd != 0) begin errors++; $display("[TB] FAIL first_rd_cycle: %0d, required 0", firstRd); end
        checks++;
        if (firstWr != 14) begin errors++; $display("[TB] FAIL first_wr_cycle: %0d, required 14", firstWr); end
        checks++;
        if (firstWrA !== 8'd0 || firstWrB !== 8'd128) begin
            errors++;
            $display("[TB] FAIL first_wr_addr: %0d/%0d, required 0/128", firstWrA, firstWrB);
        end
        checks++;
        if (alignBad != 0) begin errors++; $display("[TB] FAIL wr_alignment: %0d misaligned cycles, required 0", alignBad); end
        checks++;
        if (wrCnt != 896) begin errors++; $display("[TB] FAIL wr_count: %0d, required 896", wrCnt); end
        checks++;
        if (busyCnt != 994) begin errors++; $display("[TB] FAIL busy_cycles: %0d, required 994", busyCnt); end
        checks++;
        if (doneCnt != 1) begin errors++; $display("[TB] FAIL done_pulses: %0d, required 1", doneCnt); end
        checks++;
        if (doneAt != 994) begin errors++; $display("[TB] FAIL done_cycle: %0d, required 994", doneAt); end
        checks++;
        if (doneBusy !== 1'b0) begin errors++; $display("[TB] FAIL busy_at_done: %b, required 0", doneBusy); end
    endtask

    task automatic test_ignored_starts();
        int idleBad = 0;
        int busyCnt = 0;
        int doneAt = -1;
        int modeBad = 0;
        @(negedge clk);
        start = 1'b1;
        mode  = 2'b10;
        @(negedge clk);
        start = 1'b0;
        mode  = 2'b00;
        for (int c = 0; c < 5; c++) begin
            if (busy !== 1'b0 || rd_en !== 1'b0) idleBad++;
            @(negedge clk);
        end
        checks++;
        if (idleBad != 0 || bf_mode !== 2'b00) begin
            errors++;
            $display("[TB] FAIL reserved_mode_start: active=%0d bf_mode=%b, required 0/00", idleBad, bf_mode);
        end
        applyStimulus(2'b00);
        for (int c = 0; c < 1020; c++) begin
            if (busy === 1'b1) busyCnt++;
            if (done === 1'b1) doneAt = c;
            if (bf_mode !== 2'b00) modeBad++;
            if (c == 50) begin
                start = 1'b1;
                mode  = 2'b01;
            end else if (c == 51) begin
                start = 1'b0;
                mode  = 2'b00;
            end
            @(negedge clk);
        end
        checks++;
        if (busyCnt != 994 || doneAt != 994) begin
            errors++;
            $display("[TB] FAIL busy_start_ignored: busy=%0d done_at=%0d, required 994/994", busyCnt, doneAt);
        end
        checks++;
        if (modeBad != 0) begin errors++; $display("[TB] FAIL busy_mode_kept: %0d changed cycles, required 0", modeBad); end
    endtask

    task automatic test_reset_midop();
        int busyCnt = 0;
        int doneAt = -1;
        int idleBad = 0;
        logic [44:0] outs;
        applyStimulus(2'b00);
        for (int c = 0; c < 300; c++) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || rd_en !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midop_active: busy=%b rd_en=%b, required 1/1", busy, rd_en);
        end
        #2 rst = 1'b0;
        #1;
        outs = {busy, done, rd_en, wr_en, bf_mode, rd_addr_a, rd_addr_b, tw_idx, wr_addr_a, wr_addr_b};
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("[TB] FAIL midop_async_reset: outputs %h, required 0", outs);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (wr_en !== 1'b0 || busy !== 1'b0) idleBad++;
        end
        checks++;
        if (idleBad != 0) begin errors++; $display("[TB] FAIL post_reset_idle: %0d active cycles, required 0", idleBad); end
        applyStimulus(2'b00);
        for (int c = 0; c < 1020; c++) begin
            if (busy === 1'b1) busyCnt++;
            if (done === 1'b1) doneAt = c;
            @(negedge clk);
        end
        checks++;
        if (busyCnt != 994 || doneAt != 994) begin
            errors++;
            $display("[TB] FAIL post_reset_run: busy=%0d done_at=%0d, required 994/994", busyCnt, doneAt);
        end
    endtask

    // Scenario sequence, followed by the summary line.
    initial begin
        test_reset();
        test_ntt_sweep();
        test_intt_sweep();
        test_alignment();
        test_ignored_starts();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/ntt_ctrl.md
# ntt_ctrl

In-place NTT/INTT sequencer for 256-coefficient, 16-bit polynomials; sits directly upstream of `butterfly`. It walks all 7 Cooley-Tukey (NTT) or Gentleman-Sande (INTT) layers. Each cycle it issues one butterfly's coefficient read addresses and twiddle index, and drives `butterfly.mode`. It generates the write-back strobe and addresses aligned to the butterfly's output latency. Coefficient RAM, twiddle ROM and `butterfly` are external; no coefficient data passes through this block.

## Interface
- `N`, 256: coefficients per polynomial (fixed; `LOGN` = 8).
- `BF_LAT`, 13: `butterfly` latency in cycles, from a/b/w valid to c/d valid.
- `RD_LAT`, 1: read latency of the coefficient RAM and the twiddle ROM (both equal).

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset; asynchronous assert, active-low.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `mode`  in  2  2'b00 NTT, 2'b01 INTT; sampled with `start`.
- `busy`  out  1  high from RUN entry to end of final drain.
- `done`  out  1  one-cycle pulse on completion.
- `bf_mode`  out  2  registered copy of `mode` to `butterfly.mode`.
- `rd_en`  out  1  RAM/ROM read strobe, one butterfly per cycle.
- `rd_addr_a`, `rd_addr_b`  out  8 each  coefficient read addresses (a → `butterfly.a`, b → `butterfly.b`).
- `tw_idx`  out  7  twiddle ROM index (→ `butterfly.w`).
- `wr_en`  out  1  write-back strobe for `c`/`d`.
- `wr_addr_a`, `wr_addr_b`  out  8 each  write addresses for `c`, `d`.

## Operation
- States: IDLE → RUN → DRAIN → (RUN for next layer | DONE) → IDLE.
- IDLE: `start`=1 with `mode`∈{00,01} latches `bf_mode`, clears layer `l`=0 and butterfly counter `j`=0, goes to RUN. `mode`=1x: `start` ignored.
- RUN: `rd_en`=1 every cycle, `j` 0..127. After `j`=127 issues, go to DRAIN.
- Shift s = log2(len):
  - NTT: len = 128>>l, s = 7−l.
  - INTT: len = 2<<l, s = l+1.
- g = j>>s. `rd_addr_a` = j with a 0 inserted at bit s, i.e. {j[6:s],1'b0,j[s−1:0]}. `rd_addr_b` = `rd_addr_a` | len.
- `tw_idx`: NTT = (1<<l)+g; INTT = (128>>l)−1−g. Result is always in 1..127.
- DRAIN: lasts D = RD_LAT+BF_LAT cycles after the last issue, so the layer's final write lands before the next layer reads. Then l++. If l was 6, go to DONE instead.
- DONE: `done`=1 for one cycle, then IDLE.
- `start` outside IDLE: ignored.
- Write path: delay line of depth D carries {`rd_en`, `rd_addr_a`, `rd_addr_b`} to {`wr_en`, `wr_addr_a`, `wr_addr_b`}.
- Out of scope: INTT final scaling by n⁻¹ and bit-reversal reorder.
- Reset mid-operation: immediately IDLE; all outputs 0; delay line valid bits cleared. RAM contents are undefined afterwards.

## Timing
- Reset value of every output: 0.
- `start` sampled at edge e0. First `rd_en` is in the cycle after e0, with `busy`=1.
- Each layer takes 128 issue cycles + D drain cycles. With defaults D=14: 142 per layer, 994 cycles total with `busy`=1.
- `wr_en` asserts exactly D cycles after the corresponding `rd_en`. It is 128 consecutive cycles per layer.
- `done` is high in the cycle after the last DRAIN cycle, with `busy`=0. A `start` is accepted the cycle after `done`.

## Structure
- Shared package `ntt_pkg`: N, LOGN, mode codes NTT=2'b00 and INTT=2'b01 (shared with `butterfly`), and the state encoding.
- One sub-module: `ntt_delay_line`.
  - Parameterized depth and width; async active-low clear.
  - Used for the read-to-write alignment.

## Test plan
- Reset: hold `rst`=0 with `start` toggling → all outputs 0, `busy`=0.
- NTT address sweep:
  - l=0, j=0: a=0, b=128, tw=1.
  - l=0, j=127: a=127, b=255, tw=1.
  - l=1, j=64: a=128, b=192, tw=3.
  - l=6, j=0: a=0, b=2, tw=64.
  - l=6, j=127: a=253, b=255, tw=127.
- INTT address sweep:
  - l=0, j=0: a=0, b=2, tw=127.
  - l=0, j=2: a=4, b=6, tw=126.
  - l=6, j=0: a=0, b=128, tw=1.
- Alignment and duration:
  - First `wr_en` 14 cycles after first `rd_en`, with wr_addr 0/128.
  - `busy` high exactly 994 cycles; `done` 1 cycle.
  - End-to-end with `butterfly` and RAM models: output matches the golden Kyber NTT of a random polynomial.
- Ignored starts: `start` pulses at busy-cycle 50, and `mode`=2'b10 in IDLE → no effect; cycle counts unchanged.
- Reset mid-op: `rst`=0 at busy-cycle 300 → outputs 0 asynchronously. After release, a new `start` completes in 994 cycles.
